// File: rtl/sense_rate_counter.sv
// sense_rate_counter
//   Front end of the clock-sense path. Synchronises an external sensed clock,
//   detects its edges, runs a rate counter (primary-clock cycles since the last
//   accepted edge), latches half-period measurements when the downstream
//   filter accepts an edge, and flags a stall when the sensed clock stops.
//
// Ports
//   clk_i                  primary clock
//   rst_n_i                asynchronous active-low reset
//   enable_i               block enable (0 forces IDLE)
//   clear_i                synchronous restart of measurement (to ARMED)
//   sense_clk_i            external sensed clock, asynchronous to clk_i
//   filtered_event_i       filter accept pulse for the current sense_event_o
//   sensed_level_o         synchronised sensed-clock level
//   sense_event_o          one-cycle pulse on any sensed edge
//   current_rate_counter_o cycles since last accepted edge, minus one
//   measured_rate_o        last completed half-period measurement
//   measured_valid_o       one-cycle pulse when measured_rate_o updates
//   tracking_o             high in TRACKING
//   stalled_o              high in STALLED
//   protocol_error_o       sticky: filter accept seen without a sensed edge
//
// COUNTER_WIDTH defaults to the width used across the clock-sense path (10).
module sense_rate_counter #(
    parameter int unsigned                SYNC_STAGES   = 2,
    parameter int unsigned                COUNTER_WIDTH = 10,
    parameter logic [COUNTER_WIDTH-1:0]   STALL_LIMIT   = {{(COUNTER_WIDTH-1){1'b1}}, 1'b0}
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     sense_clk_i,
    input  logic                     filtered_event_i,
    output logic                     sensed_level_o,
    output logic                     sense_event_o,
    output logic [COUNTER_WIDTH-1:0] current_rate_counter_o,
    output logic [COUNTER_WIDTH-1:0] measured_rate_o,
    output logic                     measured_valid_o,
    output logic                     tracking_o,
    output logic                     stalled_o,
    output logic                     protocol_error_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        TRACKING = 2'd2,
        STALLED  = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [SYNC_STAGES-1:0]    sync_q, sync_d;     // sync_q[0] is the first stage
    logic                      prev_q, prev_d;
    logic [COUNTER_WIDTH-1:0]  counter_q, counter_d;
    logic [COUNTER_WIDTH-1:0]  measured_rate_q, measured_rate_d;
    logic                      measured_valid_q, measured_valid_d;
    logic                      protocol_error_q, protocol_error_d;

    logic                      sense_event;
    logic                      accepted;

    assign accepted = filtered_event_i && sense_event;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else if (clear_i) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED, TRACKING: begin
                    // An accepted edge at the stall limit is still a valid
                    // measurement, so it wins over stall detection.
                    if (accepted) begin
                        state_d = TRACKING;
                    end else if (counter_q == STALL_LIMIT) begin
                        state_d = STALLED;
                    end
                end
                STALLED: begin
                    if (accepted) begin
                        state_d = TRACKING;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        sense_event = (sync_q[SYNC_STAGES-1] ^ prev_q) && (state_q != IDLE);
        tracking_o  = (state_q == TRACKING);
        stalled_o   = (state_q == STALLED);
    end

    // ---------------------------------------------------------------- datapath next
    always_comb begin
        sync_d           = {sync_q[SYNC_STAGES-2:0], sense_clk_i};
        prev_d           = sync_q[SYNC_STAGES-1];
        measured_rate_d  = measured_rate_q;
        measured_valid_d = 1'b0;
        protocol_error_d = protocol_error_q;

        if (!enable_i || clear_i || state_q == IDLE || accepted) begin
            counter_d = '0;
        end else if (counter_q == '1) begin
            counter_d = counter_q;
        end else begin
            counter_d = counter_q + 1'b1;
        end

        // Only TRACKING knows where the interval started; the first edge out
        // of ARMED or STALLED merely restarts the count.
        if (enable_i && !clear_i && state_q == TRACKING && accepted) begin
            measured_rate_d  = counter_q;
            measured_valid_d = 1'b1;
        end

        if (clear_i) begin
            protocol_error_d = 1'b0;
        end else if (filtered_event_i && !sense_event) begin
            protocol_error_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------- datapath regs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q           <= '0;
            prev_q           <= 1'b0;
            counter_q        <= '0;
            measured_rate_q  <= '0;
            measured_valid_q <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            sync_q           <= sync_d;
            prev_q           <= prev_d;
            counter_q        <= counter_d;
            measured_rate_q  <= measured_rate_d;
            measured_valid_q <= measured_valid_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign sensed_level_o         = sync_q[SYNC_STAGES-1];
    assign sense_event_o          = sense_event;
    assign current_rate_counter_o = counter_q;
    assign measured_rate_o        = measured_rate_q;
    assign measured_valid_o       = measured_valid_q;
    assign protocol_error_o       = protocol_error_q;

endmodule

// File: tb/tb_sense_rate_counter.sv
// Testbench for sense_rate_counter: scenario tasks drive the sensed clock and
// the filter response, push expected measurements to a scoreboard queue, and
// a negedge monitor pops and compares whenever measured_valid_o pulses.
module tb_sense_rate_counter;

    localparam int CW   = 10;
    localparam int HALF = 10;   // sensed half-period in primary-clock cycles

    logic clk, rst_n, enable, clear, sense_clk;
    logic tie, reject, manual;
    logic filtered;

    logic          sensed_level_o, sense_event_o, measured_valid_o;
    logic          tracking_o, stalled_o, protocol_error_o;
    logic [CW-1:0] current_rate_counter_o, measured_rate_o;

    int errors = 0;
    int checks = 0;
    logic [CW-1:0] sb_q[$];

    // Filter model: accept every sensed edge unless told to reject one,
    // or drive a free-standing pulse when untied.
    assign filtered = tie ? (sense_event_o & ~reject) : manual;

    sense_rate_counter #(
        .SYNC_STAGES  (2),
        .COUNTER_WIDTH(CW),
        .STALL_LIMIT  (10'd1000)
    ) dut (
        .clk_i                 (clk),
        .rst_n_i               (rst_n),
        .enable_i              (enable),
        .clear_i               (clear),
        .sense_clk_i           (sense_clk),
        .filtered_event_i      (filtered),
        .sensed_level_o        (sensed_level_o),
        .sense_event_o         (sense_event_o),
        .current_rate_counter_o(current_rate_counter_o),
        .measured_rate_o       (measured_rate_o),
        .measured_valid_o      (measured_valid_o),
        .tracking_o            (tracking_o),
        .stalled_o             (stalled_o),
        .protocol_error_o      (protocol_error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && measured_valid_o) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_measurement got=%0d exp=none", measured_rate_o);
            end else begin
                automatic logic [CW-1:0] exp_rate = sb_q.pop_front();
                if (measured_rate_o !== exp_rate) begin
                    errors++;
                    $display("FAIL measured_rate got=%0d exp=%0d", measured_rate_o, exp_rate);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; sense_clk = 1'b0;
        tie = 1'b1; reject = 1'b0; manual = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    // Toggle the sensed clock and run one half-period, recording the first
    // sensed edge, the counter seen in that cycle and the valid flag after it.
    task automatic drive_half(input bit accept, output bit seen,
                              output logic [CW-1:0] cnt_ev, output logic valid_after);
        int ev_c;
        ev_c = -10; seen = 1'b0; cnt_ev = '0; valid_after = 1'b0;
        reject = !accept;
        sense_clk = ~sense_clk;
        for (int c = 0; c < HALF; c++) begin
            step();
            if (c == ev_c + 1) valid_after = measured_valid_o;
            if (sense_event_o && !seen) begin
                seen   = 1'b1;
                ev_c   = c;
                cnt_ev = current_rate_counter_o;
            end
        end
        reject = 1'b0;
    endtask

    task automatic test_reset();
        bit ev_seen;
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; sense_clk = 1'b0;
        tie = 1'b1; reject = 1'b0; manual = 1'b0;
        repeat (2) begin sense_clk = ~sense_clk; step(); end
        checks++;
        if ({sensed_level_o, sense_event_o, current_rate_counter_o, measured_rate_o,
             measured_valid_o, tracking_o, stalled_o, protocol_error_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {sensed_level_o, sense_event_o, current_rate_counter_o, measured_rate_o,
                      measured_valid_o, tracking_o, stalled_o, protocol_error_o});
        end
        sense_clk = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();
        sense_clk = 1'b1;
        step();
        checks++;
        if (sensed_level_o !== 1'b0) begin
            errors++; $display("FAIL idle_level_1cyc got=%b exp=0", sensed_level_o);
        end
        step();
        checks++;
        if (sensed_level_o !== 1'b1) begin
            errors++; $display("FAIL idle_level_2cyc got=%b exp=1", sensed_level_o);
        end
        ev_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) sense_clk = ~sense_clk;
            step();
            if (sense_event_o || tracking_o || stalled_o || current_rate_counter_o != 0) ev_seen = 1'b1;
        end
        checks++;
        if (ev_seen !== 1'b0) begin
            errors++; $display("FAIL idle_quiet got=%b exp=0", ev_seen);
        end
    endtask

    task automatic test_edge_latency();
        sense_clk = 1'b0;
        repeat (4) step();
        enable = 1'b1;
        repeat (3) step();
        sense_clk = 1'b1;
        step();
        checks++;
        if ({sensed_level_o, sense_event_o} !== 2'b00) begin
            errors++; $display("FAIL latency_edge_k got=%b exp=00", {sensed_level_o, sense_event_o});
        end
        step();
        checks++;
        if ({sensed_level_o, sense_event_o} !== 2'b11) begin
            errors++; $display("FAIL latency_edge_k1 got=%b exp=11", {sensed_level_o, sense_event_o});
        end
        step();
        checks++;
        if ({sensed_level_o, sense_event_o, tracking_o} !== 3'b101) begin
            errors++; $display("FAIL latency_after got=%b exp=101", {sensed_level_o, sense_event_o, tracking_o});
        end
    endtask

    task automatic test_steady_tracking();
        bit seen; logic [CW-1:0] cnt; logic vld;
        do_reset();
        enable = 1'b1;
        repeat (2) step();
        drive_half(1'b1, seen, cnt, vld);
        checks++;
        if ({seen, vld, tracking_o} !== 3'b101) begin
            errors++; $display("FAIL first_event got=%b exp=101", {seen, vld, tracking_o});
        end
        for (int i = 1; i < 6; i++) begin
            sb_q.push_back(CW'(HALF - 1));
            drive_half(1'b1, seen, cnt, vld);
            checks++;
            if ({seen, vld} !== 2'b11 || cnt !== CW'(HALF - 1)) begin
                errors++; $display("FAIL steady_event got=%b/%0d exp=11/%0d", {seen, vld}, cnt, HALF - 1);
            end
            checks++;
            if (current_rate_counter_o !== CW'(HALF - 3)) begin
                errors++; $display("FAIL steady_ramp got=%0d exp=%0d", current_rate_counter_o, HALF - 3);
            end
        end
    endtask

    task automatic test_rejected_event();
        bit seen; logic [CW-1:0] cnt; logic vld;
        drive_half(1'b0, seen, cnt, vld);
        checks++;
        if ({seen, vld} !== 2'b10) begin
            errors++; $display("FAIL rejected_no_meas got=%b exp=10", {seen, vld});
        end
        sb_q.push_back(CW'(2 * HALF - 1));
        drive_half(1'b1, seen, cnt, vld);
        checks++;
        if ({seen, vld} !== 2'b11 || cnt !== CW'(2 * HALF - 1)) begin
            errors++; $display("FAIL rejected_next got=%b/%0d exp=11/%0d", {seen, vld}, cnt, 2 * HALF - 1);
        end
        sb_q.push_back(CW'(HALF - 1));
        drive_half(1'b1, seen, cnt, vld);
    endtask

    task automatic test_stall_recovery();
        bit seen; logic [CW-1:0] cnt; logic vld;
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 1100 && !reached; i++) begin
            if (current_rate_counter_o == 10'd1000) reached = 1'b1;
            else step();
        end
        checks++;
        if (!reached) begin
            errors++; $display("FAIL stall_limit_reach got=%0d exp=1000", current_rate_counter_o);
        end
        checks++;
        if ({stalled_o, tracking_o} !== 2'b01) begin
            errors++; $display("FAIL stall_at_limit got=%b exp=01", {stalled_o, tracking_o});
        end
        step();
        checks++;
        if ({stalled_o, tracking_o} !== 2'b10 || current_rate_counter_o !== 10'd1001) begin
            errors++; $display("FAIL stalled got=%b/%0d exp=10/1001", {stalled_o, tracking_o}, current_rate_counter_o);
        end
        repeat (30) step();
        checks++;
        if (current_rate_counter_o !== '1) begin
            errors++; $display("FAIL counter_saturate got=%0d exp=1023", current_rate_counter_o);
        end
        drive_half(1'b1, seen, cnt, vld);
        checks++;
        if ({seen, vld, tracking_o, stalled_o} !== 4'b1010) begin
            errors++; $display("FAIL resume_first got=%b exp=1010", {seen, vld, tracking_o, stalled_o});
        end
        sb_q.push_back(CW'(HALF - 1));
        drive_half(1'b1, seen, cnt, vld);
        checks++;
        if ({seen, vld} !== 2'b11 || cnt !== CW'(HALF - 1)) begin
            errors++; $display("FAIL resume_second got=%b/%0d exp=11/%0d", {seen, vld}, cnt, HALF - 1);
        end
    endtask

    task automatic test_protocol_and_priority();
        bit seen; logic [CW-1:0] cnt; logic vld;
        logic [CW-1:0] c0;
        c0 = current_rate_counter_o;
        tie = 1'b0; manual = 1'b1;
        step();
        tie = 1'b1; manual = 1'b0;
        checks++;
        if ({protocol_error_o, tracking_o} !== 2'b11 || current_rate_counter_o !== c0 + 1'b1) begin
            errors++; $display("FAIL perr_set got=%b/%0d exp=11/%0d", {protocol_error_o, tracking_o},
                               current_rate_counter_o, c0 + 1'b1);
        end
        repeat (3) step();
        checks++;
        if (protocol_error_o !== 1'b1) begin
            errors++; $display("FAIL perr_sticky got=%b exp=1", protocol_error_o);
        end
        sb_q.push_back(CW'(HALF + 3));
        drive_half(1'b1, seen, cnt, vld);
        checks++;
        if (cnt !== CW'(HALF + 3)) begin
            errors++; $display("FAIL perr_counter_unaffected got=%0d exp=%0d", cnt, HALF + 3);
        end
        // clear_i in the same cycle as an accepted edge
        sense_clk = ~sense_clk;
        repeat (2) step();
        checks++;
        if (sense_event_o !== 1'b1) begin
            errors++; $display("FAIL clear_edge_present got=%b exp=1", sense_event_o);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({tracking_o, stalled_o, protocol_error_o, measured_valid_o} !== 4'b0000 ||
            current_rate_counter_o !== '0) begin
            errors++; $display("FAIL clear_priority got=%b/%0d exp=0000/0",
                               {tracking_o, stalled_o, protocol_error_o, measured_valid_o}, current_rate_counter_o);
        end
        repeat (HALF - 3) step();
        drive_half(1'b1, seen, cnt, vld);
        checks++;
        if ({seen, vld, tracking_o} !== 3'b101) begin
            errors++; $display("FAIL rearm_first got=%b exp=101", {seen, vld, tracking_o});
        end
        sb_q.push_back(CW'(HALF - 1));
        drive_half(1'b1, seen, cnt, vld);
        // enable_i drop during TRACKING
        repeat (3) step();
        enable = 1'b0;
        step();
        checks++;
        if ({tracking_o, measured_valid_o} !== 2'b00 || current_rate_counter_o !== '0 ||
            measured_rate_o !== CW'(HALF - 1)) begin
            errors++; $display("FAIL disable got=%b/%0d/%0d exp=00/0/%0d", {tracking_o, measured_valid_o},
                               current_rate_counter_o, measured_rate_o, HALF - 1);
        end
    endtask

    task automatic test_midop_reset();
        bit ev;
        ev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) sense_clk = ~sense_clk;
            step();
            if (sense_event_o) ev = 1'b1;
        end
        checks++;
        if (ev !== 1'b0) begin
            errors++; $display("FAIL idle_no_event got=%b exp=0", ev);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({current_rate_counter_o, measured_rate_o, measured_valid_o, tracking_o,
             stalled_o, protocol_error_o} !== '0) begin
            errors++; $display("FAIL async_reset got=%0d/%0d exp=0/0", current_rate_counter_o, measured_rate_o);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_steady_tracking();
        test_rejected_event();
        test_stall_recovery();
        test_protocol_and_priority();
        test_midop_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sense_rate_counter.md
Name: sense_rate_counter

Overview:
- Front-end stage of the clock-sense path, directly upstream of the sense filter.
- Synchronises the external sensed clock and detects its edges.
- Maintains the running rate counter (primary-clock cycles since the last accepted edge).
- Latches half-period measurements, using the filter's accept pulse as feedback, and flags stalls when the sensed clock stops toggling.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on sense_clk_i (min 2).
- COUNTER_WIDTH, clks_alot_p::COUNTER_WIDTH, width of the rate counter and measurements.
- STALL_LIMIT, 2**COUNTER_WIDTH-2, counter value at which the sensed clock is declared stalled.

Ports:
- clk_i  in  1  primary clock
- rst_n_i  in  1  asynchronous active-low reset
- enable_i  in  1  block enable
- clear_i  in  1  synchronous restart of measurement (to ARMED)
- sense_clk_i  in  1  external sensed clock, asynchronous to clk_i
- filtered_event_i  in  1  filter accept pulse for the current sense_event_o
- sensed_level_o  out  1  synchronised sensed-clock level (feeds the filter's level input)
- sense_event_o  out  1  one-cycle pulse on any sensed edge
- current_rate_counter_o  out  COUNTER_WIDTH  cycles since last accepted edge, minus one
- measured_rate_o  out  COUNTER_WIDTH  last completed half-period measurement
- measured_valid_o  out  1  one-cycle pulse when measured_rate_o updates
- tracking_o  out  1  high in TRACKING
- stalled_o  out  1  high in STALLED
- protocol_error_o  out  1  sticky: filtered_event_i seen without sense_event_o

Behaviour:
- Reset: all flops 0. Every output reads 0; state IDLE.
- Synchroniser chain s[0..SYNC_STAGES-1] and prev register run in all states.
  - sensed_level_o = s[last].
  - sense_event_o = s[last] XOR prev (combinational from flops).
  - A level change first sampled at clk edge k gives sense_event_o high for exactly the cycle after edge k+SYNC_STAGES-1.
  - sense_event_o is forced to 0 in IDLE.
- Accepted event = filtered_event_i AND sense_event_o.
- filtered_event_i high while sense_event_o is low:
  - the pulse is ignored;
  - protocol_error_o sets next cycle and stays set until reset or clear_i.
- Counter:
  - counter <= 0 on an accepted event, in IDLE, or on clear_i.
  - Otherwise counter <= counter+1, saturating at all-ones.
  - current_rate_counter_o = counter, registered.
- States:
  - IDLE: enable_i=0. Counter held at 0. measured_rate_o holds its last value. Go to ARMED when enable_i=1.
  - ARMED: counter runs. The first accepted event moves to TRACKING; no measurement is emitted because the interval start is unknown.
  - TRACKING: each accepted event does measured_rate_o <= counter and pulses measured_valid_o in the next cycle (1-cycle latency); the counter clears.
  - STALLED: stalled_o=1. The next accepted event goes to TRACKING, clears the counter, and emits no measurement.
- Stall detection: from ARMED or TRACKING, counter == STALL_LIMIT with no accepted event that cycle moves to STALLED next cycle.
- Priority (highest first):
  1. enable_i=0 forces IDLE (from any state).
  2. clear_i forces ARMED, clears counter and protocol_error_o.
  3. Accepted event.
  4. Stall detection.
- An accepted event in the same cycle as counter == STALL_LIMIT is a valid measurement; it does not stall.
- Reset mid-operation: immediate return to reset values, including measured_rate_o.

Test Plan:
- Reset and idle:
  - rst_n_i low, then enable_i=0 with sense_clk_i toggling.
  - All outputs 0. sensed_level_o follows sense_clk_i after 2 cycles. No sense_event_o.
- Edge latency (SYNC_STAGES=2):
  - enable_i=1; sense_clk_i rises before clk edge 10.
  - sensed_level_o=1 and sense_event_o=1 only in the cycle after edge 11.
- Steady tracking:
  - sense_clk_i toggles every 10 cycles; filtered_event_i tied to sense_event_o.
  - First event: ARMED to TRACKING, no measured_valid_o.
  - Thereafter measured_rate_o=9 with measured_valid_o pulsing every 10 cycles; current_rate_counter_o ramps 0..9.
- Rejected event:
  - Same stimulus, but filtered_event_i held 0 for one edge.
  - Counter continues; next accepted event gives measured_rate_o=19.
- Stall and recovery (STALL_LIMIT=1000):
  - Stop toggling.
  - stalled_o=1 the cycle after counter reaches 1000, tracking_o=0.
  - On resume, the first accepted edge gives no measurement; the second gives 9.
- Protocol error and priority:
  - filtered_event_i pulses with sense_event_o=0: protocol_error_o sets and stays; counter unaffected.
  - clear_i and an accepted event in the same cycle: ARMED, counter 0, no measurement.
  - enable_i drops during TRACKING: IDLE next cycle, counter 0, measured_rate_o held.
